// File: rtl/pair_mlt3_transmitter_pkg.sv
// Shared line-coding definitions for the pair MLT-3 transmitter:
// 5-bit control/data codes, the 4B5B data table, FSM state and MLT-3 level types.
package pair_line_pkg;

   // Minimum /I/ symbols between /R/ and the next /J/
   localparam int unsigned IPG_SYMBOLS = 12;

   // Scrambler seed (only consumed when the scrambler is compiled in)
   localparam logic [10:0] SCR_SEED = 11'h7FF;

   // Control codes, transmitted MSB (bit 4) first
   localparam logic [4:0] CODE_I = 5'b11111;
   localparam logic [4:0] CODE_J = 5'b11000;
   localparam logic [4:0] CODE_K = 5'b10001;
   localparam logic [4:0] CODE_T = 5'b01101;
   localparam logic [4:0] CODE_R = 5'b00111;
   localparam logic [4:0] CODE_H = 5'b00100;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SSD_J = 3'd1,
      ST_SSD_K = 3'd2,
      ST_DATA  = 3'd3,
      ST_ESD_T = 3'd4,
      ST_ESD_R = 3'd5,
      ST_IPG   = 3'd6
   } tx_state_e;

   // Bit 0 drives PairPos, bit 1 drives PairNeg; 2'b11 is never produced
   typedef enum logic [1:0] {
      MLT3_ZERO = 2'b00,
      MLT3_POS  = 2'b01,
      MLT3_NEG  = 2'b10
   } mlt3_level_e;

   // Standard 4B5B data mapping
   function automatic logic [4:0] nib_to_code(input logic [3:0] nib);
      logic [4:0] code;
      case (nib)
         4'h0:    code = 5'b11110;
         4'h1:    code = 5'b01001;
         4'h2:    code = 5'b10100;
         4'h3:    code = 5'b10101;
         4'h4:    code = 5'b01010;
         4'h5:    code = 5'b01011;
         4'h6:    code = 5'b01110;
         4'h7:    code = 5'b01111;
         4'h8:    code = 5'b10010;
         4'h9:    code = 5'b10011;
         4'hA:    code = 5'b10110;
         4'hB:    code = 5'b10111;
         4'hC:    code = 5'b11010;
         4'hD:    code = 5'b11011;
         4'hE:    code = 5'b11100;
         4'hF:    code = 5'b11101;
         default: code = 5'b11110;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/pair_mlt3_transmitter_if.sv
// Nibble stream handshake into the pair transmitter.
interface pair_mlt3_transmitter_if;
   logic [3:0] TxData;
   logic       TxValid;
   logic       TxLast;
   logic       TxReady;

   modport master (output TxData, output TxValid, output TxLast, input TxReady);
   modport slave  (input TxData, input TxValid, input TxLast, output TxReady);
endinterface

// File: rtl/pair_mlt3_transmitter_mlt3.sv
// MLT-3 level encoder: a 1 advances 0 -> +1 -> 0 -> -1 -> 0, a 0 holds the level.
// The level register drives the pair outputs directly.
module mlt3_level_encoder
   import pair_line_pkg::*;
(
   input  logic Clock100MhzP,
   input  logic ResetN,
   input  logic serial_bit,
   output logic PairPos,
   output logic PairNeg
);

   mlt3_level_e level_q, level_d;
   mlt3_level_e last_nz_q, last_nz_d;

   // Next level and remembered polarity from the current serial bit
   always_comb begin
      level_d   = level_q;
      last_nz_d = last_nz_q;
      if (serial_bit) begin
         case (level_q)
            MLT3_ZERO: level_d = (last_nz_q == MLT3_POS) ? MLT3_NEG : MLT3_POS;
            MLT3_POS, MLT3_NEG: begin
               level_d   = MLT3_ZERO;
               last_nz_d = level_q;
            end
            default:   level_d = MLT3_ZERO;
         endcase
      end else begin
         level_d = level_q;
      end
   end

   // Level state; reset parks at 0 with -1 remembered so the first step is +1
   always_ff @(posedge Clock100MhzP) begin
      if (!ResetN) begin
         level_q   <= MLT3_ZERO;
         last_nz_q <= MLT3_NEG;
      end else begin
         level_q   <= level_d;
         last_nz_q <= last_nz_d;
      end
   end

   assign PairPos = level_q[0];
   assign PairNeg = level_q[1];

endmodule

// File: rtl/pair_mlt3_transmitter.sv
// Pair MLT-3 transmitter: frames a nibble stream with /J/K/ ... /T/R/, 4B5B-encodes,
// serialises MSB first at one bit per clock and drives MLT-3 onto PairPos/PairNeg.
// Optional build macro PAIR_SCRAMBLER_EN inserts an x^11+x^9+1 scrambler before MLT-3.
module pair_mlt3_transmitter
   import pair_line_pkg::*;
(
   input  logic                      Clock100MhzP,
   input  logic                      ResetN,
   pair_mlt3_transmitter_if.slave    tx,
   output logic                      PairPos,
   output logic                      PairNeg,
   output logic                      Busy,
   output logic                      Underrun
);

   logic [2:0] sym_cnt_q, sym_cnt_d;
   tx_state_e  state_q, state_d;
   logic [4:0] shift_q, shift_d;
   logic [3:0] ipg_cnt_q, ipg_cnt_d;
   logic       ended_q, ended_d;
   logic       ready_q, ready_d;
   logic       busy_q, busy_d;
   logic       underrun_q, underrun_d;
   logic       accept_s;
   logic       line_bit_s;

   assign accept_s = ready_q & tx.TxValid;

   // Symbol sequencing: the next code is chosen in the SymCnt==4 cycle
   always_comb begin
      sym_cnt_d  = (sym_cnt_q == 3'd4) ? 3'd0 : sym_cnt_q + 3'd1;
      state_d    = state_q;
      shift_d    = {shift_q[3:0], 1'b0};
      ipg_cnt_d  = ipg_cnt_q;
      ended_d    = ended_q;
      underrun_d = 1'b0;
      if (sym_cnt_q == 3'd4) begin
         case (state_q)
            ST_IDLE: begin
               if (tx.TxValid) begin
                  state_d = ST_SSD_J;
                  shift_d = CODE_J;
               end else begin
                  shift_d = CODE_I;
               end
            end
            ST_SSD_J: begin
               state_d = ST_SSD_K;
               shift_d = CODE_K;
            end
            ST_SSD_K, ST_DATA: begin
               if (ended_q) begin
                  // Last nibble (or /H/) already sent: close the frame
                  state_d = ST_ESD_T;
                  shift_d = CODE_T;
                  ended_d = 1'b0;
               end else if (accept_s) begin
                  state_d = ST_DATA;
                  shift_d = nib_to_code(tx.TxData);
                  ended_d = tx.TxLast;
               end else begin
                  // Source starved us: mark the frame bad and terminate
                  state_d    = ST_DATA;
                  shift_d    = CODE_H;
                  ended_d    = 1'b1;
                  underrun_d = 1'b1;
               end
            end
            ST_ESD_T: begin
               state_d = ST_ESD_R;
               shift_d = CODE_R;
            end
            ST_ESD_R: begin
               state_d   = ST_IPG;
               shift_d   = CODE_I;
               ipg_cnt_d = 4'd0;
            end
            ST_IPG: begin
               shift_d = CODE_I;
               if (ipg_cnt_q == 4'(IPG_SYMBOLS - 1)) begin
                  state_d = ST_IDLE;
               end else begin
                  ipg_cnt_d = ipg_cnt_q + 4'd1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               shift_d = CODE_I;
               ended_d = 1'b0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Registered ready lines up with the SymCnt==4 decision cycle
   always_comb begin
      ready_d = (sym_cnt_q == 3'd3) &&
                ((state_q == ST_SSD_K) || ((state_q == ST_DATA) && !ended_q));
      busy_d  = (state_d != ST_IDLE);
   end

   // Framing state, shifter and registered status outputs
   always_ff @(posedge Clock100MhzP) begin
      if (!ResetN) begin
         sym_cnt_q  <= 3'd0;
         state_q    <= ST_IDLE;
         shift_q    <= CODE_I;
         ipg_cnt_q  <= 4'd0;
         ended_q    <= 1'b0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         sym_cnt_q  <= sym_cnt_d;
         state_q    <= state_d;
         shift_q    <= shift_d;
         ipg_cnt_q  <= ipg_cnt_d;
         ended_q    <= ended_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         underrun_q <= underrun_d;
      end
   end

`ifdef PAIR_SCRAMBLER_EN
   logic [10:0] lfsr_q, lfsr_d;
   logic        scr_bit_s;

   assign scr_bit_s  = lfsr_q[10] ^ lfsr_q[8];
   assign line_bit_s = shift_q[4] ^ scr_bit_s;

   // Free-running scrambler, advancing every cycle including idle
   always_comb begin
      lfsr_d = {lfsr_q[9:0], scr_bit_s};
   end

   // Scrambler state register
   always_ff @(posedge Clock100MhzP) begin
      if (!ResetN) begin
         lfsr_q <= SCR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end
`else
   assign line_bit_s = shift_q[4];
`endif

   mlt3_level_encoder u_mlt3 (
      .Clock100MhzP (Clock100MhzP),
      .ResetN       (ResetN),
      .serial_bit   (line_bit_s),
      .PairPos      (PairPos),
      .PairNeg      (PairNeg)
   );

   assign tx.TxReady = ready_q;
   assign Busy       = busy_q;
   assign Underrun   = underrun_q;

endmodule

// File: tb/tb_pair_mlt3_transmitter.sv
// Directed bench for pair_mlt3_transmitter (scrambler not compiled in).
// Line bits are recovered from the pair: a level change is a 1, no change a 0.
module tb_pair_mlt3_transmitter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic pair_pos, pair_neg, busy, underrun;
   int   tests = 0;
   int   fails = 0;
   int   phase = 0;

   pair_mlt3_transmitter_if tx_if ();

   pair_mlt3_transmitter dut (
      .Clock100MhzP (clk),
      .ResetN       (rst_n),
      .tx           (tx_if),
      .PairPos      (pair_pos),
      .PairNeg      (pair_neg),
      .Busy         (busy),
      .Underrun     (underrun)
   );

   always #5 clk = ~clk;

   // Bench's own symbol-phase model: 0..4 from reset
   always @(posedge clk) begin
      if (!rst_n) phase <= 0;
      else        phase <= (phase == 4) ? 0 : phase + 1;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive ResetN low for one edge; returns at the negedge after reset took effect
   task automatic hit_reset();
      @(negedge clk);
      rst_n = 1'b0;
      tx_if.TxValid = 1'b0;
      @(negedge clk);
   endtask

   // Start a frame at a SymCnt==4 boundary t and record L line bits from t+2.
   // nibs holds n entries of {last, data}; masks are indexed by cycle offset from t.
   task automatic run_frame(input logic [39:0] nibs, input int n, input int L,
                            output logic [127:0] cap, output logic [127:0] rmask,
                            output logic [127:0] umask, output logic [127:0] bmask,
                            output int both_high);
      int idx;
      bit acc;
      logic [1:0] lvl, prev_lvl;
      logic [4:0] ent;
      cap = '0; rmask = '0; umask = '0; bmask = '0; both_high = 0;
      for (int w = 0; w < 10 && phase != 4; w++) @(negedge clk);
      idx = 0;
      ent = nibs[4:0];
      tx_if.TxData  = ent[3:0];
      tx_if.TxLast  = ent[4];
      tx_if.TxValid = 1'b1;
      bmask[0] = busy;
      prev_lvl = {pair_neg, pair_pos};
      acc = 1'b0;
      for (int k = 1; k <= L + 1; k++) begin
         @(negedge clk);
         if (acc) begin
            idx++;
            if (idx < n) begin
               ent = nibs[idx*5 +: 5];
               tx_if.TxData = ent[3:0];
               tx_if.TxLast = ent[4];
            end else begin
               tx_if.TxValid = 1'b0;
            end
         end
         lvl = {pair_neg, pair_pos};
         if (k >= 2) cap = {cap[126:0], (lvl !== prev_lvl)};
         prev_lvl = lvl;
         if (lvl == 2'b11) both_high++;
         rmask[k] = tx_if.TxReady;
         umask[k] = underrun;
         bmask[k] = busy;
         acc = tx_if.TxReady && tx_if.TxValid;
      end
   endtask

   // After a reset negedge: release and check idle MLT-3 sequence 0,+1,0,-1
   task automatic check_idle_after_reset(input string tag);
      logic [1:0] exp_lvl;
      logic any_rdy, any_busy;
      any_rdy = 1'b0; any_busy = 1'b0;
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         case (k % 4)
            1:       exp_lvl = 2'b01;
            3:       exp_lvl = 2'b10;
            default: exp_lvl = 2'b00;
         endcase
         chk($sformatf("%s_lvl%0d", tag, k), {126'd0, pair_neg, pair_pos}, {126'd0, exp_lvl});
         any_rdy  = any_rdy | tx_if.TxReady;
         any_busy = any_busy | busy;
      end
      chk({tag, "_ready_idle"}, {127'd0, any_rdy}, 128'd0);
      chk({tag, "_busy_idle"}, {127'd0, any_busy}, 128'd0);
   endtask

   initial begin
      logic [127:0] cap, rmask, umask, bmask;
      int both;
      tx_if.TxData  = 4'h0;
      tx_if.TxLast  = 1'b0;
      tx_if.TxValid = 1'b0;

      // Reset state and idle line pattern
      hit_reset();
      chk("rst_pos", {127'd0, pair_pos}, 128'd0);
      chk("rst_neg", {127'd0, pair_neg}, 128'd0);
      chk("rst_ready", {127'd0, tx_if.TxReady}, 128'd0);
      chk("rst_busy", {127'd0, busy}, 128'd0);
      chk("rst_underrun", {127'd0, underrun}, 128'd0);
      check_idle_after_reset("idle");

      // One-nibble frame 5, last
      hit_reset(); rst_n = 1'b1;
      run_frame({35'd0, 5'h15}, 1, 30, cap, rmask, umask, bmask, both);
      chk("one_bits", cap, {98'd0, 25'b11000_10001_01011_01101_00111, 5'b11111});
      chk("one_ready", rmask, 128'd1 << 10);
      chk("one_underrun", umask, 128'd0);
      chk("one_busy_t0", {127'd0, bmask[0]}, 128'd0);
      chk("one_busy_t1", {127'd0, bmask[1]}, 128'd1);
      chk("one_both_high", 128'(both), 128'd0);

      // Four-nibble frame 1,2,3,4 with TxValid held
      hit_reset(); rst_n = 1'b1;
      run_frame({20'd0, 5'h14, 5'h03, 5'h02, 5'h01}, 4, 40, cap, rmask, umask, bmask, both);
      chk("four_bits", cap,
          {88'd0, 40'b11000_10001_01001_10100_10101_01010_01101_00111});
      chk("four_ready", rmask, (128'd1 << 10) | (128'd1 << 15) | (128'd1 << 20) | (128'd1 << 25));
      chk("four_underrun", umask, 128'd0);
      chk("four_both_high", 128'(both), 128'd0);

      // Underrun: only one non-last nibble supplied
      hit_reset(); rst_n = 1'b1;
      run_frame({35'd0, 5'h03}, 1, 30, cap, rmask, umask, bmask, both);
      chk("ur_bits", cap, {98'd0, 30'b11000_10001_10101_00100_01101_00111});
      chk("ur_ready", rmask, (128'd1 << 10) | (128'd1 << 15));
      chk("ur_pulse", umask, 128'd1 << 16);

      // Second frame requested straight after the first
      hit_reset(); rst_n = 1'b1;
      run_frame({30'd0, 5'h1A, 5'h15}, 2, 115, cap, rmask, umask, bmask, both);
      chk("b2b_bits", cap, {13'd0, 25'b11000_10001_01011_01101_00111, {65{1'b1}},
                            25'b11000_10001_10110_01101_00111});
      chk("b2b_ready", rmask, (128'd1 << 10) | (128'd1 << 100));
      chk("b2b_busy_gap", {43'd0, bmask[85:1]}, {43'd0, {85{1'b1}}});
      chk("b2b_busy_idle", {123'd0, bmask[90:86]}, 128'd0);
      chk("b2b_busy_j2", {127'd0, bmask[91]}, 128'd1);
      chk("b2b_both_high", 128'(both), 128'd0);

      // Reset in the middle of DATA
      hit_reset(); rst_n = 1'b1;
      run_frame({20'd0, 5'h14, 5'h03, 5'h02, 5'h01}, 4, 16, cap, rmask, umask, bmask, both);
      hit_reset();
      chk("mid_pos", {127'd0, pair_pos}, 128'd0);
      chk("mid_neg", {127'd0, pair_neg}, 128'd0);
      chk("mid_ready", {127'd0, tx_if.TxReady}, 128'd0);
      chk("mid_busy", {127'd0, busy}, 128'd0);
      chk("mid_underrun", {127'd0, underrun}, 128'd0);
      check_idle_after_reset("mid");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
